// File: rtl/vault_pkg.sv
// Shared types and default constants for the vault PIN-check controller.
package vault_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StCheck,
        StOpen,
        StLockout
    } vaultState_e;

    localparam int unsigned DigitWidth = 4;

    localparam int unsigned DefDigits       = 4;
    localparam int unsigned DefMaxTries     = 3;
    localparam int unsigned DefOpenCycles   = 1000;
    localparam int unsigned DefLockCycles   = 5000;
    localparam int unsigned DefEntryTimeout = 2000;
    localparam logic [15:0] DefPin          = 16'hAAAA;

    function automatic int unsigned maxOf3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vault_timer.sv
// Loadable down-counter shared by the entry, open and lockout phases.
module vault_timer #(
    parameter int unsigned Width = 13
) (
    input  logic             ClockSource,
    input  logic             ResetN,
    input  logic             Load,
    input  logic [Width-1:0] LoadValue,
    output logic             Expired
);

    logic [Width-1:0] countQ;
    logic             runningQ;

    always_ff @(posedge ClockSource or negedge ResetN) begin
        if (!ResetN) begin
            countQ   <= '0;
            runningQ <= 1'b0;
        end else if (Load) begin
            countQ   <= LoadValue;
            runningQ <= 1'b1;
        end else if (runningQ) begin
            if (countQ == '0) begin
                runningQ <= 1'b0;
            end else begin
                countQ <= countQ - 1'b1;
            end
        end
    end

    assign Expired = runningQ && (countQ == '0);

endmodule

// File: rtl/vault_access_ctrl.sv
// PIN-entry sequencer: digit-serial compare against a stored PIN, open/close control,
// failed-attempt counting and timed lockout.
module vault_access_ctrl
    import vault_pkg::*;
#(
    parameter int unsigned             DIGITS        = DefDigits,
    parameter int unsigned             MAX_TRIES     = DefMaxTries,
    parameter int unsigned             OPEN_CYCLES   = DefOpenCycles,
    parameter int unsigned             LOCK_CYCLES   = DefLockCycles,
    parameter int unsigned             ENTRY_TIMEOUT = DefEntryTimeout,
    parameter logic [4*DIGITS-1:0]     DEFAULT_PIN   = DefPin
) (
    input  logic                             ClockSource,
    input  logic                             ResetN,
    input  logic [3:0]                       Digit,
    input  logic                             DigitValid,
    input  logic                             Clear,
    input  logic                             CloseReq,
    input  logic                             ProgReq,
    input  logic [4*DIGITS-1:0]              ProgPin,
    output logic                             SafeOpen,
    output logic                             Locked,
    output logic                             AccessFail,
    output logic [$clog2(MAX_TRIES+1)-1:0]   FailCount
);

    localparam int unsigned MaxCycles  = maxOf3(OPEN_CYCLES, LOCK_CYCLES, ENTRY_TIMEOUT);
    localparam int unsigned TimerWidth = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam int unsigned IdxWidth   = $clog2(DIGITS + 1);
    localparam int unsigned FcWidth    = $clog2(MAX_TRIES + 1);

    // Loaded with N-1 so the expiry edge lands exactly N cycles after the load edge.
    localparam logic [TimerWidth-1:0] EntryLoad = TimerWidth'(ENTRY_TIMEOUT - 1);
    localparam logic [TimerWidth-1:0] OpenLoad  = TimerWidth'(OPEN_CYCLES - 1);
    localparam logic [TimerWidth-1:0] LockLoad  = TimerWidth'(LOCK_CYCLES - 1);

    vaultState_e               stateQ, stateD;
    logic [IdxWidth-1:0]       idxQ, idxD;
    logic                      flagQ, flagD;
    logic [FcWidth-1:0]        failCountQ, failCountD;
    logic [4*DIGITS-1:0]       pinQ, pinD;
    logic                      accessFailD;
    logic                      timerLoad;
    logic [TimerWidth-1:0]     timerValue;
    logic                      timerExpired;
    logic [DigitWidth-1:0]     expDigit;
    logic                      digitMatch;
    int                        nibbleIdx;

    vault_timer #(
        .Width(TimerWidth)
    ) uTimer (
        .ClockSource(ClockSource),
        .ResetN     (ResetN),
        .Load       (timerLoad),
        .LoadValue  (timerValue),
        .Expired    (timerExpired)
    );

    // Digit i is checked against nibble DIGITS-1-i (first digit is the MS nibble).
    always_comb begin
        nibbleIdx = 0;
        if (int'(idxQ) < int'(DIGITS)) begin
            nibbleIdx = int'(DIGITS) - 1 - int'(idxQ);
        end
        expDigit   = pinQ[DigitWidth*nibbleIdx +: DigitWidth];
        digitMatch = &(Digit ~^ expDigit);
    end

    always_comb begin
        stateD      = stateQ;
        idxD        = idxQ;
        flagD       = flagQ;
        failCountD  = failCountQ;
        pinD        = pinQ;
        accessFailD = 1'b0;
        timerLoad   = 1'b0;
        timerValue  = '0;
        case (stateQ)
            StIdle: begin
                if (DigitValid) begin
                    flagD      = !digitMatch;
                    idxD       = IdxWidth'(1);
                    timerLoad  = 1'b1;
                    timerValue = EntryLoad;
                    stateD     = (DIGITS == 1) ? StCheck : StEntry;
                end
            end
            StEntry: begin
                if (Clear) begin
                    idxD   = '0;
                    flagD  = 1'b0;
                    stateD = StIdle;
                end else if (DigitValid) begin
                    flagD      = flagQ | !digitMatch;
                    idxD       = idxQ + 1'b1;
                    timerLoad  = 1'b1;
                    timerValue = EntryLoad;
                    if (idxQ == IdxWidth'(DIGITS - 1)) begin
                        stateD = StCheck;
                    end
                end else if (timerExpired) begin
                    flagD  = 1'b1;
                    stateD = StCheck;
                end
            end
            StCheck: begin
                idxD  = '0;
                flagD = 1'b0;
                if (!flagQ) begin
                    failCountD = '0;
                    timerLoad  = 1'b1;
                    timerValue = OpenLoad;
                    stateD     = StOpen;
                end else begin
                    accessFailD = 1'b1;
                    failCountD  = failCountQ + 1'b1;
                    if (failCountD == FcWidth'(MAX_TRIES)) begin
                        timerLoad  = 1'b1;
                        timerValue = LockLoad;
                        stateD     = StLockout;
                    end else begin
                        stateD = StIdle;
                    end
                end
            end
            StOpen: begin
                if (ProgReq) begin
                    pinD = ProgPin;
                end
                if (CloseReq || timerExpired) begin
                    stateD = StIdle;
                end
            end
            StLockout: begin
                if (timerExpired) begin
                    failCountD = '0;
                    stateD     = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge ClockSource or negedge ResetN) begin
        if (!ResetN) begin
            stateQ     <= StIdle;
            idxQ       <= '0;
            flagQ      <= 1'b0;
            failCountQ <= '0;
            pinQ       <= DEFAULT_PIN;
            SafeOpen   <= 1'b0;
            Locked     <= 1'b0;
            AccessFail <= 1'b0;
        end else begin
            stateQ     <= stateD;
            idxQ       <= idxD;
            flagQ      <= flagD;
            failCountQ <= failCountD;
            pinQ       <= pinD;
            SafeOpen   <= (stateD == StOpen);
            Locked     <= (stateD == StLockout);
            AccessFail <= accessFailD;
        end
    end

    assign FailCount = failCountQ;

endmodule
